// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioner and the display counter:
// debounce FSM encodings, default timing constants and a small sizing helper.
package key_debounce_pulse_pkg;

  localparam int CLK_HZ = 50_000_000;
  // 20 ms of stable input at CLK_HZ
  localparam int DEF_DB_CYCLES = CLK_HZ / 50;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } db_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; the reset value is
// chosen per input so an idle line does not look active coming out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button debouncer producing a clean count clock (cnt_clk) plus press and
// release strobes. Define AUTO_REPEAT_EN to emit repeat presses while held.
module key_debounce_pulse
  import key_debounce_pulse_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       cnt_clk,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX =
    CNT_W'(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) - 1);

  logic             key_s;
  db_state_e        state, state_d;
  logic [CNT_W-1:0] timer, timer_d, timer_inc;
  logic             key_level_d, press_d, release_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  // Saturating increment: the timer must never wrap back into a match
  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic repeating, repeating_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) repeating <= 1'b0;
    else        repeating <= repeating_d;
  end
`endif

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    key_level_d = key_level;
    press_d     = 1'b0;
    release_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
    repeating_d = repeating;
`endif
    case (state)
      ST_IDLE: begin
        timer_d = '0;
        if (!key_s) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (key_s) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer == DB_LAST) begin
          state_d     = ST_PRESSED;
          timer_d     = '0;
          key_level_d = 1'b0;
          press_d     = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_PRESSED: begin
        if (key_s) begin
          state_d = ST_RELEASE_WAIT;
          timer_d = '0;
`ifdef AUTO_REPEAT_EN
          repeating_d = 1'b0;
`endif
        end else begin
`ifdef AUTO_REPEAT_EN
          // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
          if (timer == (repeating ? RP_LAST : RD_LAST)) begin
            press_d     = 1'b1;
            timer_d     = '0;
            repeating_d = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
`else
          timer_d = '0;
`endif
        end
      end
      ST_RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = ST_PRESSED;
          timer_d = '0;
        end else if (timer == DB_LAST) begin
          state_d     = ST_IDLE;
          timer_d     = '0;
          key_level_d = 1'b1;
          release_d   = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      key_level     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      cnt_clk       <= 1'b1;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      key_level     <= key_level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      cnt_clk       <= ~press_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Randomised bench for key_debounce_pulse: a run-length model of the debounce
// rules predicts every output cycle; honours AUTO_REPEAT_EN like the DUT.
module tb_key_debounce_pulse;

  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic       clock;
  logic       reset;
  logic       key_n;
  logic       key_level, press_pulse, release_pulse, cnt_clk;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce_pulse #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .CNT_W         (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key_n         (key_n),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .cnt_clk       (cnt_clk),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: {key_level, press, release, cnt_clk} expected after each edge
  logic [3:0] exp_q[$];
  logic       hist[$];
  bit         m_level = 1'b1;
  int         m_run = 0;
  int         m_held = 0;
  int         m_presses = 0;

  always @(posedge clock) begin
    bit s, p, r;
    p = 1'b0;
    r = 1'b0;
    if (!reset) begin
      hist.delete();
      m_level = 1'b1;
      m_run   = 0;
      m_held  = 0;
    end else begin
      hist.push_back(key_n);
      if (hist.size() > 3) void'(hist.pop_front());
      s = (hist.size() == 3) ? hist[0] : 1'b1;
      if (s != m_level) begin
        // a new level is accepted after DB+1 consecutive differing samples
        m_run++;
        if (m_run == DB + 1) begin
          m_level = s;
          m_run   = 0;
          m_held  = 0;
          if (!m_level) p = 1'b1;
          else          r = 1'b1;
        end
      end else begin
        if (!m_level) begin
          if (m_run > 0) m_held = 0;
          else begin
            m_held++;
`ifdef AUTO_REPEAT_EN
            if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) p = 1'b1;
`endif
          end
        end
        m_run = 0;
      end
    end
    if (p) m_presses++;
    exp_q.push_back({m_level, p, r, ~p});
  end

  // scoreboard
  always @(negedge clock) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("key_level", 32'(key_level), 32'(e[3]));
      check("press_pulse", 32'(press_pulse), 32'(e[2]));
      check("release_pulse", 32'(release_pulse), 32'(e[1]));
      check("cnt_clk", 32'(cnt_clk), 32'(e[0]));
    end
  end

  // downstream display counter stand-in: advances on falling cnt_clk
  logic [3:0] disp = 4'd0;
  always @(negedge cnt_clk) disp <= disp + 4'd1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] t[16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  // driver tasks
  task automatic hold(input logic v, input int cycles);
    key_n = v;
    repeat (cycles) begin
      @(negedge clock);
      #1;
    end
  endtask

  initial begin
    logic [3:0] disp0;
    int         pr0;
    reset = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b1;

    hold(1'b0, 30);
    hold(1'b1, 30);
    // press bounce
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 20);
    hold(1'b1, 20);
    // reset while debouncing a held key
    hold(1'b0, 5);
    reset = 1'b0;
    #1;
    check("rst_key_level", 32'(key_level), 32'd1);
    check("rst_press", 32'(press_pulse), 32'd0);
    check("rst_release", 32'(release_pulse), 32'd0);
    check("rst_cnt_clk", 32'(cnt_clk), 32'd1);
    hold(1'b0, 3);
    reset = 1'b1;
    hold(1'b0, 20);
    hold(1'b1, 20);
    // long hold, then release bounce back into pressed
    hold(1'b0, 80);
    hold(1'b1, 20);
    hold(1'b0, 40);
    hold(1'b1, 4);
    hold(1'b0, 45);
    hold(1'b1, 20);
    // random activity
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) hold(1'(($urandom_range(0, 1))), $urandom_range(30, 70));
      else hold(1'(($urandom_range(0, 1))), $urandom_range(1, 14));
    end
    hold(1'b1, 20);
    // sixteen clean presses wrap the display counter
    disp0 = disp;
    pr0   = m_presses;
    for (int i = 0; i < 16; i++) begin
      hold(1'b0, 14);
      hold(1'b1, 14);
    end
    hold(1'b1, 5);
    check("wrap_presses", 32'(m_presses - pr0), 32'd16);
    check("wrap_segments", 32'(seg7(disp - disp0)), 32'(7'b1000000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
